regfile_write_arbiter: RTL

//  Shares the register file's single write port between two requesters:
//   - pipeline writeback (wb_*)
//   - late load-return path (ld_*)

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rf_arb_scoreboard.sv | 77 +++++++
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants and request type for the register-file write arbiter.
//   REG_IDX_W   : register index width
//   DATA_W      : register-file write data width
//   NUM_REGS    : number of architectural registers
//   rf_wr_req_t : one write request (destination, data, half-load flag)
// -----------------------------------------------------------------------------
package rf_arb_pkg;

   localparam int REG_IDX_W = 4;
   localparam int DATA_W    = 16;
   localparam int NUM_REGS  = 16;

   typedef struct packed {
      logic [3:0]  dst;
      logic [15:0] data;
      logic        half;
   } rf_wr_req_t;

endpackage

// File: rtl/rf_arb_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_arb_scoreboard
// Pending-load scoreboard. Decode reserves a destination when it issues a load.
// The load-return transfer clears it again.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   rsv_valid  : reserve request from decode
//   rsv_reg    : register being reserved (R0 ignored)
//   clr_valid  : load-return transfer this cycle
//   clr_reg    : destination of the load-return transfer (R0 ignored)
//   pending    : bit i set while a load write to Ri is outstanding
//   rsv_err    : 1-cycle pulse, reservation of a register that stays pending
// -----------------------------------------------------------------------------
module rf_arb_scoreboard
   import rf_arb_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rsv_valid,
   input  logic [3:0]          rsv_reg,
   input  logic                clr_valid,
   input  logic [3:0]          clr_reg,
   output logic [NUM_REGS-1:0] pending,
   output logic                rsv_err
);

   logic [NUM_REGS-1:0] pending_r;
   logic [NUM_REGS-1:0] pending_nxt_s;
   logic                rsv_s;
   logic                clr_s;
   logic                rsv_err_s;
   logic                rsv_err_r;

   // Next scoreboard value: the clear is applied first so a same-cycle set wins.
   always_comb begin
      rsv_s         = rsv_valid && (rsv_reg != 4'd0);
      clr_s         = clr_valid && (clr_reg != 4'd0);
      pending_nxt_s = pending_r;
      if (clr_s) begin
         pending_nxt_s[clr_reg] = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
      if (rsv_s) begin
         pending_nxt_s[rsv_reg] = 1'b1;
      end else begin
         pending_nxt_s = pending_nxt_s;
      end
   end

   // A double reservation is an error only if the bit is not being retired now.
   always_comb begin
      rsv_err_s = 1'b0;
      if (rsv_s && pending_r[rsv_reg] && !(clr_s && (clr_reg == rsv_reg))) begin
         rsv_err_s = 1'b1;
      end else begin
         rsv_err_s = 1'b0;
      end
   end

   // Scoreboard and error-pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= '0;
         rsv_err_r <= 1'b0;
      end else begin
         pending_r <= pending_nxt_s;
         rsv_err_r <= rsv_err_s;
      end
   end

   assign pending = pending_r;
   assign rsv_err = rsv_err_r;

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the register file's single write port between pipeline writeback (wb)
// and the late load-return path (ld). The write port is driven from registers.
// The block also keeps the pending-load scoreboard used by decode to stall.
// Configuration macro RF_ARB_STARVE_GUARD_EN:
//   defined   : ld refused MAX_WAIT times in a row wins the next contention
//   undefined : strict priority, wb always beats ld
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   wb_valid/ready/reg/data/half      : writeback requester
//   ld_valid/ready/reg/data/half      : load-return requester
//   rsv_valid, rsv_reg                : decode reservation of a load destination
//   pending, rsv_err                  : scoreboard and double-reservation pulse
//   rf_write, rf_dst, rf_data, rf_half: registered register-file write port
// -----------------------------------------------------------------------------
module regfile_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int DATA_W   = 16,
   parameter int MAX_WAIT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [3:0]          wb_reg,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                wb_half,
   input  logic                ld_valid,
   output logic                ld_ready,
   input  logic [3:0]          ld_reg,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic                ld_half,
   input  logic                rsv_valid,
   input  logic [3:0]          rsv_reg,
   output logic [NUM_REGS-1:0] pending,
   output logic                rsv_err,
   output logic                rf_write,
   output logic [3:0]          rf_dst,
   output logic [DATA_W-1:0]   rf_data,
   output logic                rf_half
);

   logic       ld_force_s;
   logic       xfer_s;
   rf_wr_req_t sel_req_s;
   rf_wr_req_t rf_req_r;
   logic       rf_write_r;

`ifdef RF_ARB_STARVE_GUARD_EN
   logic [3:0] wait_cnt_r;

   // ld has been refused long enough to take the port on the next contention.
   always_comb begin
      ld_force_s = (wait_cnt_r == 4'(MAX_WAIT));
   end

   // Count consecutive refusals of a waiting ld; saturate at MAX_WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= 4'd0;
      end else if (ld_valid && !ld_ready) begin
         if (wait_cnt_r != 4'(MAX_WAIT)) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
      end else begin
         wait_cnt_r <= 4'd0;
      end
   end
`else
   // Without the aging counter ld never overrides wb.
   always_comb begin
      ld_force_s = 1'b0;
   end
`endif

   // Grant logic: one grant per cycle, nothing granted while in reset.
   always_comb begin
      wb_ready = 1'b0;
      ld_ready = 1'b0;
      if (rst) begin
         wb_ready = 1'b0;
         ld_ready = 1'b0;
      end else if (wb_valid && ld_valid) begin
         wb_ready = !ld_force_s;
         ld_ready = ld_force_s;
      end else begin
         wb_ready = wb_valid;
         ld_ready = ld_valid;
      end
   end

   // Select the granted request for the write-port register.
   always_comb begin
      sel_req_s = '0;
      xfer_s    = 1'b0;
      if (wb_ready) begin
         sel_req_s.dst  = wb_reg;
         sel_req_s.data = wb_data;
         sel_req_s.half = wb_half;
         xfer_s         = 1'b1;
      end else if (ld_ready) begin
         sel_req_s.dst  = ld_reg;
         sel_req_s.data = ld_data;
         sel_req_s.half = ld_half;
         xfer_s         = 1'b1;
      end else begin
         sel_req_s = '0;
         xfer_s    = 1'b0;
      end
   end

   // Write-port register; writes to R0 complete the handshake but never reach the file.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_write_r <= 1'b0;
         rf_req_r   <= '0;
      end else if (xfer_s && (sel_req_s.dst != 4'd0)) begin
         rf_write_r <= 1'b1;
         rf_req_r   <= sel_req_s;
      end else begin
         rf_write_r <= 1'b0;
         rf_req_r   <= rf_req_r;
      end
   end

   assign rf_write = rf_write_r;
   assign rf_dst   = rf_req_r.dst;
   assign rf_data  = rf_req_r.data;
   assign rf_half  = rf_req_r.half;

   rf_arb_scoreboard #(
      .NUM_REGS (NUM_REGS)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .rsv_valid (rsv_valid),
      .rsv_reg   (rsv_reg),
      .clr_valid (ld_ready),
      .clr_reg   (ld_reg),
      .pending   (pending),
      .rsv_err   (rsv_err)
   );

endmodule
